// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences an external 1-bit full-adder cell LSB first,
// holding cell inputs for SETTLE cycles before sampling its sum and carry.
module serial_add_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_y1,
  input  logic             fa_y0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] settle_q;
  logic             fa_a_q;
  logic             fa_b_q;
  logic             fa_c_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign idx_d = idx_q + IDX_W'(1);

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      settle_q <= '0;
      fa_a_q   <= 1'b0;
      fa_b_q   <= 1'b0;
      fa_c_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            carry_q  <= cin;
            idx_q    <= '0;
            settle_q <= '0;
            fa_a_q   <= a_in[0];
            fa_b_q   <= b_in[0];
            fa_c_q   <= cin;
            busy_q   <= 1'b1;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          settle_q <= settle_q + CNT_W'(1);
          if (settle_q == SETTLE_END) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          sum_q[idx_q] <= fa_y0;
          carry_q      <= fa_y1;
          settle_q     <= '0;
          if (idx_q == LAST_IDX) begin
            cout_q  <= fa_y1;
            fa_a_q  <= 1'b0;
            fa_b_q  <= 1'b0;
            fa_c_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            // Next bit's cell inputs go out on the same edge the carry is captured.
            idx_q   <= idx_d;
            fa_a_q  <= a_q[idx_d];
            fa_b_q  <= b_q[idx_d];
            fa_c_q  <= fa_y1;
            state_q <= DRIVE;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fa_a = fa_a_q;
  assign fa_b = fa_b_q;
  assign fa_c = fa_c_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl; the full-adder cell is modelled with one cycle of delay.
module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam int S = 2;
  localparam int LAT = W * (S + 1);

  logic clk;
  logic rst;
  logic start, cin, fa_a, fa_b, fa_c, fa_y1, fa_y0, busy, done, cout;
  logic [W-1:0] a_in, b_in, sum;
  logic start1, cin1, fa_a1, fa_b1, fa_c1, fa_y11, fa_y01, busy1, done1, cout1;
  logic [W-1:0] a_in1, b_in1, sum1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W), .SETTLE(S)) u0 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_y1(fa_y1), .fa_y0(fa_y0),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(W), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a_in1), .b_in(b_in1), .cin(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1), .fa_y1(fa_y11), .fa_y0(fa_y01),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-adder cells with a one-cycle output delay
  always_ff @(posedge clk) begin
    {fa_y1, fa_y0}   <= {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_c};
    {fa_y11, fa_y01} <= {1'b0, fa_a1} + {1'b0, fa_b1} + {1'b0, fa_c1};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One addition on u0, checked cycle by cycle against arithmetic expectations.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int glitch_lat, input string tag);
    logic [W:0]   full;
    logic [W-1:0] old_sum, mask;
    logic         old_cout;
    int lat, i, m, ci, bad_pins, bad_sum, bad_busy;
    full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    old_sum  = exp_sum;
    old_cout = exp_cout;
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bad_pins = 0; bad_sum = 0; bad_busy = 0;
    while (done !== 1'b1 && lat < LAT + 20) begin
      i = lat / (S + 1);
      if (i > W) i = W;
      if (i < W) begin
        m  = (1 << i) - 1;
        ci = (((int'(a) & m) + (int'(b) & m) + int'(c)) >> i) & 1;
        if (fa_a !== a[i] || fa_b !== b[i] || fa_c !== ci[0]) bad_pins++;
      end
      mask = W'((1 << i) - 1);
      if (sum !== ((full[W-1:0] & mask) | (old_sum & ~mask)) || cout !== old_cout) bad_sum++;
      if (busy !== 1'b1) bad_busy++;
      if (glitch_lat >= 0 && lat == glitch_lat) begin
        start = 1'b1; a_in = ~a; b_in = 8'h35; cin = ~c;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sum"}, sum, full[W-1:0]);
    chk({tag, "_cout"}, cout, full[W]);
    chk({tag, "_cell_inputs"}, bad_pins, 0);
    chk({tag, "_partial_sum"}, bad_sum, 0);
    chk({tag, "_busy_run"}, bad_busy, 0);
    chk({tag, "_finish_busy_fa"}, {busy, fa_a, fa_b, fa_c}, 4'b1000);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {done, busy, fa_a, fa_b, fa_c}, 5'b0);
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
  endtask

  initial begin : stim
    int t, prev, w, seen, lat;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    start1 = 1'b0; a_in1 = '0; b_in1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u0", {busy, done, fa_a, fa_b, fa_c, cout, sum}, '0);
    chk("rst_u1", {busy1, done1, fa_a1, fa_b1, fa_c1, cout1, sum1}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", busy, 0);

    do_op(8'hFF, 8'h01, 1'b0, -1, "ff_01");
    do_op(8'h5A, 8'hA5, 1'b1, -1, "5a_a5");
    for (int n = 0; n < 6; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1, $sformatf("rand%0d", n));
    end
    do_op(W'($urandom), W'($urandom), 1'($urandom), 9, "glitch_bit3");

    // start held high: back-to-back additions
    a_in = 8'h03; b_in = 8'h04; cin = 1'b0; start = 1'b1;
    t = 0; prev = 0;
    for (int n = 0; n < 3; n++) begin
      w = 0;
      do begin
        @(posedge clk); #1;
        t++; w++;
      end while (done !== 1'b1 && w < 100);
      chk($sformatf("b2b_done%0d", n), done, 1);
      chk($sformatf("b2b_sum%0d", n), sum, 8'h07);
      chk($sformatf("b2b_cout%0d", n), cout, 0);
      if (n > 0) chk($sformatf("b2b_gap%0d", n), t - prev, LAT + 2);
      prev = t;
      if (n == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_idle", busy, 0);
    exp_sum = 8'h07; exp_cout = 1'b0;

    // Reset during CAPTURE of bit 5
    a_in = 8'h3C; b_in = 8'h7E; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5 * (S + 1) + S) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {busy, done, fa_a, fa_b, fa_c}, 5'b0);
    chk("async_rst_result", {cout, sum}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (LAT + 6) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    exp_sum = '0; exp_cout = 1'b0;
    do_op(8'h10, 8'h20, 1'b0, -1, "post_rst");

    // SETTLE=1 instance
    a_in1 = 8'h80; b_in1 = 8'h80; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("s1_latency", lat, W * 2);
    chk("s1_sum", sum1, 8'h00);
    chk("s1_cout", cout1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
